umem_arbiter: RTL and testbench
===============================

Name: umem_arbiter

Overview:
- Sequencer for a single shared memory port. Arbitrates between the pipeline's instruction-fetch path and its data-access path (MEM stage, 2-bit write/read control).
- Runs each granted access as a request/ready transaction on a variable-latency memory.
- Returns read data and a one-cycle ack to the winning requester.
- Drives a stall to the pipeline while any request is outstanding. Sits between the CPU core and a unified memory model, replacing separate I/D memories.

Parameters:
- WIDTH, 32, data word width.
- ADDRWIDTH, 32, address width.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits (range 1..15).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  ADDRWIDTH  fetch address.
- if_rdata_o  out  WIDTH  fetched word; valid when if_ack_o=1.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- d_ctrl_i  in  2  data request control: bit1 write, bit0 read; 2'b00 means no request. Held until d_ack_o.
- d_addr_i  in  ADDRWIDTH  data address.
- d_wdata_i  in  WIDTH  write data.
- d_rdata_o  out  WIDTH  read data; valid when d_ack_o=1.
- d_ack_o  out  1  one-cycle completion pulse for data.
- mem_req_o  out  1  memory request; held until mem_ready_i.
- mem_we_o  out  1  1 = write transaction.
- mem_addr_o  out  ADDRWIDTH  memory address.
- mem_wdata_o  out  WIDTH  memory write data.
- mem_rdata_i  in  WIDTH  memory read data; valid with mem_ready_i.
- mem_ready_i  in  1  memory completion, sampled only while mem_req_o=1.
- stall_o  out  1  pipeline stall.

Behaviour:
- Reset values: state=IDLE; all outputs 0 (ack, rdata, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o); starvation counter=0.
- d_req = |d_ctrl_i. d_ctrl_i=2'b11 is treated as a write; d_rdata_o is still loaded from mem_rdata_i.
- FSM states: IDLE, XFER_I, XFER_D, DONE.
- IDLE, no request: remain in IDLE.
- IDLE, only one request: grant it.
- IDLE, both requesting: grant data unless the counter equals STARVE_LIMIT, in which case grant fetch.
- On a grant: latch address, write data and we into the mem_* registers; mem_req_o=1 from the next cycle. Go to XFER_I or XFER_D.
- XFER_x: hold all mem_* outputs stable. On mem_ready_i=1, register mem_rdata_i into that side's rdata_o and pulse its ack_o in the next cycle (DONE). Clear mem_req_o in the same edge.
- DONE: exactly one ack high for one cycle. Return to IDLE. The requester drops its request in the DONE cycle, so IDLE never re-grants a completed request.
- Minimum latency is 2 cycles: request in cycle 0, mem_req_o in cycle 1, ready in cycle 1, ack in cycle 2. Each extra cycle without ready adds 1. Back-to-back transactions are separated by one IDLE cycle.
- Starvation counter:
  - Increments on each data grant made while if_req_i=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant.
  - Clears in any IDLE cycle with if_req_i=0.
- rdata_o holds its last value between acks. The other side's rdata and ack are unchanged.
- stall_o is registered: 1 from the cycle after any request appears in IDLE, through DONE inclusive. It is 0 in IDLE when no request is pending.
- A request withdrawn mid-XFER does not abort. The transaction completes and the ack still pulses.
- mem_ready_i while mem_req_o=0 is ignored.
- rst_i in any state: next cycle is IDLE with all outputs at reset values. An in-flight transaction is abandoned without ack; the memory model must tolerate mem_req_o dropping.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=0x10, memory answers 0xDEADBEEF with ready in the same cycle. Expect mem_req_o=1 with mem_addr_o=0x10, mem_we_o=0 at cycle 1; if_ack_o=1 and if_rdata_o=0xDEADBEEF at cycle 2; stall_o high in cycles 1–2.
- Data write with 3 wait cycles: d_ctrl_i=2'b10, d_addr_i=0x40, d_wdata_i=0x12345678. Expect mem_we_o=1, mem_wdata_o=0x12345678 held for 4 cycles; a single d_ack_o pulse; if_ack_o stays 0.
- Simultaneous requests with STARVE_LIMIT=2 and data requests re-asserted each time. Expect grant order D, D, I, D, D, I. Counter visibly resets after each fetch grant.
- Withdrawal: if_req_i drops during XFER_I. Expect the transaction to finish and if_ack_o to pulse once; no second grant follows.
- Reset mid-transaction: rst_i=1 for one cycle during XFER_D. Expect mem_req_o=0, stall_o=0, no ack, and state IDLE next cycle. A subsequent fetch completes normally.
- Read with both control bits set: d_ctrl_i=2'b11. Expect mem_we_o=1 and d_rdata_o loaded from mem_rdata_i with d_ack_o.

Source files
------------

// File: rtl/umem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : umem_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch and data access, with a bounded-starvation grant policy.
// Revision    : 1.0 - initial release
// ============================================================================
module umem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDRWIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 if_req_i,
    input  logic [ADDRWIDTH-1:0] if_addr_i,
    output logic [WIDTH-1:0]     if_rdata_o,
    output logic                 if_ack_o,
    input  logic [1:0]           d_ctrl_i,
    input  logic [ADDRWIDTH-1:0] d_addr_i,
    input  logic [WIDTH-1:0]     d_wdata_i,
    output logic [WIDTH-1:0]     d_rdata_o,
    output logic                 d_ack_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDRWIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]     mem_wdata_o,
    input  logic [WIDTH-1:0]     mem_rdata_i,
    input  logic                 mem_ready_i,
    output logic                 stall_o
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_xfer_i = 2'd1;
    localparam logic [1:0] c_st_xfer_d = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [WIDTH-1:0]     r_if_rdata;
    logic                 r_if_ack;
    logic [WIDTH-1:0]     r_d_rdata;
    logic                 r_d_ack;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [ADDRWIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0]     r_mem_wdata;
    logic                 r_stall;

    logic w_d_req;
    logic w_grant_d;
    logic w_grant_i;

    // Data wins ties until fetch has been passed over STARVE_LIMIT times.
    assign w_d_req   = |d_ctrl_i;
    assign w_grant_d = w_d_req && (!if_req_i || (r_cnt != c_limit));
    assign w_grant_i = if_req_i && !w_grant_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_st_idle;
            r_cnt       <= 4'd0;
            r_if_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_d_rdata   <= '0;
            r_d_ack     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_stall     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_stall <= if_req_i | w_d_req;
                    if (w_grant_d) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_ctrl_i[1];
                        r_mem_addr  <= d_addr_i;
                        r_mem_wdata <= d_wdata_i;
                        r_state     <= c_st_xfer_d;
                        if (!if_req_i) begin
                            r_cnt <= 4'd0;
                        end else if (r_cnt != c_limit) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else if (w_grant_i) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr_i;
                        r_mem_wdata <= d_wdata_i;
                        r_state     <= c_st_xfer_i;
                        r_cnt       <= 4'd0;
                    end else begin
                        r_cnt <= 4'd0;
                    end
                end
                c_st_xfer_i: begin
                    r_stall <= 1'b1;
                    if (mem_ready_i) begin
                        r_mem_req  <= 1'b0;
                        r_if_rdata <= mem_rdata_i;
                        r_if_ack   <= 1'b1;
                        r_state    <= c_st_done;
                    end
                end
                c_st_xfer_d: begin
                    r_stall <= 1'b1;
                    if (mem_ready_i) begin
                        r_mem_req <= 1'b0;
                        r_d_rdata <= mem_rdata_i;
                        r_d_ack   <= 1'b1;
                        r_state   <= c_st_done;
                    end
                end
                default: begin
                    // The finished requester drops here; keep stalling only if the other still waits.
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_stall  <= if_req_i | w_d_req;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

    assign if_rdata_o  = r_if_rdata;
    assign if_ack_o    = r_if_ack;
    assign d_rdata_o   = r_d_rdata;
    assign d_ack_o     = r_d_ack;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign stall_o     = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_umem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_umem_arbiter
// Description : Scoreboard bench for umem_arbiter with a wait-state memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_c;
    } mem_t;

    typedef struct {
        bit          side;   // 0 = fetch, 1 = data
        logic [31:0] rdata;
    } ack_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic [1:0]  d_ctrl_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_ready_i = 1'b0;
    logic        stall_o;

    logic        spur = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    mem_t        mem_q[$];
    ack_t        ack_q[$];
    logic [31:0] mdl_if = 32'h0;
    logic [31:0] mdl_d  = 32'h0;
    int          lat_a, lat_b;

    always #5 clk = ~clk;

    umem_arbiter #(
        .WIDTH        (32),
        .ADDRWIDTH    (32),
        .STARVE_LIMIT (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .d_ctrl_i    (d_ctrl_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_rdata_o   (d_rdata_o),
        .d_ack_o     (d_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i),
        .stall_o     (stall_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int wait_c);
        mem_t m;
        m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata; m.wait_c = wait_c;
        mem_q.push_back(m);
    endtask

    task automatic push_exp(input bit side, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int wait_c);
        ack_t a;
        push_mem(we, addr, wdata, rdata, wait_c);
        a.side = side; a.rdata = rdata;
        ack_q.push_back(a);
    endtask

    task automatic req_fetch(input logic [31:0] addr, output int lat);
        if_req_i  = 1'b1;
        if_addr_i = addr;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (if_ack_o) break;
        end
        if (!if_ack_o) chk("fetch_timeout", {31'b0, if_ack_o}, 32'd1);
        if_req_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic req_data(input logic [1:0] ctrl, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat);
        d_ctrl_i  = ctrl;
        d_addr_i  = addr;
        d_wdata_i = wdata;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (d_ack_o) break;
        end
        if (!d_ack_o) chk("data_timeout", {31'b0, d_ack_o}, 32'd1);
        d_ctrl_i = 2'b00;
        @(posedge clk); #1;
    endtask

    // Memory model: answers the front expected transaction after its wait count,
    // checking the held request fields on every cycle mem_req_o is high.
    int wcnt = 0;
    always @(negedge clk) begin
        mem_t e;
        mem_ready_i = spur;
        mem_rdata_i = 32'hA5A5_5A5A;
        if (mem_req_o) begin
            if (mem_q.size() == 0) begin
                report_fail("mem_unexpected_req");
            end else begin
                e = mem_q[0];
                chk("mem_we", {31'b0, mem_we_o}, {31'b0, e.we});
                chk("mem_addr", mem_addr_o, e.addr);
                if (e.we) chk("mem_wdata", mem_wdata_o, e.wdata);
                if (wcnt == e.wait_c) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = e.rdata;
                    void'(mem_q.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    // Ack monitor: pops the expected completion whenever an ack appears.
    always @(negedge clk) begin
        ack_t a;
        if (if_ack_o && d_ack_o) report_fail("ack_both");
        if (if_ack_o || d_ack_o) begin
            if (ack_q.size() == 0) begin
                report_fail("ack_unexpected");
            end else begin
                a = ack_q.pop_front();
                chk("ack_side", {31'b0, d_ack_o}, {31'b0, a.side});
                if (a.side) begin
                    chk("d_rdata", d_rdata_o, a.rdata);
                    chk("if_rdata_hold", if_rdata_o, mdl_if);
                    mdl_d = a.rdata;
                end else begin
                    chk("if_rdata", if_rdata_o, a.rdata);
                    chk("d_rdata_hold", d_rdata_o, mdl_d);
                    mdl_if = a.rdata;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        d_ctrl_i = 2'b00; d_addr_i = '0; d_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_acks", {30'b0, if_ack_o, d_ack_o}, 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_d_rdata", d_rdata_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Single fetch, zero wait states: cycle-exact checks.
        push_exp(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        if_req_i = 1'b1; if_addr_i = 32'h10;
        @(posedge clk); #1;
        chk("f1_mem_req", {31'b0, mem_req_o}, 32'd1);
        chk("f1_mem_addr", mem_addr_o, 32'h10);
        chk("f1_mem_we", {31'b0, mem_we_o}, 32'd0);
        chk("f1_stall", {31'b0, stall_o}, 32'd1);
        @(posedge clk); #1;
        chk("f2_if_ack", {31'b0, if_ack_o}, 32'd1);
        chk("f2_if_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("f2_stall", {31'b0, stall_o}, 32'd1);
        chk("f2_mem_req", {31'b0, mem_req_o}, 32'd0);
        if_req_i = 1'b0;
        @(posedge clk); #1;
        chk("f3_stall", {31'b0, stall_o}, 32'd0);
        chk("f3_if_ack", {31'b0, if_ack_o}, 32'd0);

        // Data write with three wait states.
        push_exp(1'b1, 1'b1, 32'h40, 32'h12345678, 32'hCAFEF00D, 3);
        req_data(2'b10, 32'h40, 32'h12345678, lat_a);
        chk("wr_latency", lat_a, 32'd5);

        // Contention with STARVE_LIMIT=2: grant order D, D, I, D, D, I.
        push_exp(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_D001, 1);
        push_exp(1'b1, 1'b0, 32'h104, 32'h0, 32'h0000_D002, 0);
        push_exp(1'b0, 1'b0, 32'h200, 32'h0, 32'h0000_1001, 2);
        push_exp(1'b1, 1'b0, 32'h108, 32'h0, 32'h0000_D003, 0);
        push_exp(1'b1, 1'b0, 32'h10C, 32'h0, 32'h0000_D004, 1);
        push_exp(1'b0, 1'b0, 32'h204, 32'h0, 32'h0000_1002, 0);
        fork
            begin
                req_fetch(32'h200, lat_a);
                req_fetch(32'h204, lat_a);
            end
            begin
                req_data(2'b01, 32'h100, 32'h0, lat_b);
                req_data(2'b01, 32'h104, 32'h0, lat_b);
                req_data(2'b01, 32'h108, 32'h0, lat_b);
                req_data(2'b01, 32'h10C, 32'h0, lat_b);
            end
        join
        chk("starve_drained", ack_q.size(), 32'd0);

        // Fetch withdrawn mid-transfer still completes exactly once.
        push_exp(1'b0, 1'b0, 32'h300, 32'h0, 32'h0BADCAFE, 2);
        if_req_i = 1'b1; if_addr_i = 32'h300;
        @(posedge clk); #1;
        if_req_i = 1'b0;
        lat_a = 0;
        while (lat_a < 100 && !if_ack_o) begin
            @(posedge clk); #1;
            lat_a++;
        end
        chk("wd_ack_seen", {31'b0, if_ack_o}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("wd_no_regrant", {31'b0, mem_req_o}, 32'd0);
        end

        // Reset during XFER_D abandons the transaction.
        push_mem(1'b0, 32'h400, 32'h0, 32'h77777777, 6);
        d_ctrl_i = 2'b01; d_addr_i = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b1; d_ctrl_i = 2'b00;
        @(posedge clk); #1;
        rst_i = 1'b0;
        void'(mem_q.pop_front());
        mdl_if = 32'h0; mdl_d = 32'h0;
        chk("rs_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("rs_stall", {31'b0, stall_o}, 32'd0);
        chk("rs_acks", {30'b0, if_ack_o, d_ack_o}, 32'd0);
        chk("rs_d_rdata", d_rdata_o, 32'd0);
        @(posedge clk); #1;
        chk("rs_idle", {31'b0, mem_req_o}, 32'd0);
        push_exp(1'b0, 1'b0, 32'h500, 32'h0, 32'h55AA1234, 1);
        req_fetch(32'h500, lat_a);
        chk("rs_fetch_latency", lat_a, 32'd3);

        // Both control bits set: write transaction that still returns read data.
        push_exp(1'b1, 1'b1, 32'h600, 32'hFEEDFACE, 32'h13572468, 0);
        req_data(2'b11, 32'h600, 32'hFEEDFACE, lat_a);
        chk("rw_latency", lat_a, 32'd2);

        // Ready without a request must be ignored.
        spur = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("spur_mem_req", {31'b0, mem_req_o}, 32'd0);
            chk("spur_stall", {31'b0, stall_o}, 32'd0);
        end
        spur = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("end_ack_q_empty", ack_q.size(), 32'd0);
        chk("end_mem_q_empty", mem_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
